// File: rtl/uart_pkg.sv
// Shared UART transmit-path definitions: CPU register map, status/control bit
// positions and the drain state machine encoding.
package uart_pkg;

    localparam logic UART_REG_DATA = 1'b0;
    localparam logic UART_REG_STAT = 1'b1;

    localparam int ST_OVF   = 7;
    localparam int ST_EMPTY = 6;
    localparam int ST_FULL  = 5;

    localparam int CT_IRQEN = 0;
    localparam int CT_FLUSH = 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_ARM,
        TX_BUSY
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and an occupancy count; pointers wrap
// modulo DEPTH, so DEPTH must be a power of two.
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Fullness is judged on the pre-edge count, so a push into a full FIFO is
    // dropped even when a pop frees a slot on the same edge.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-facing transmit buffer that drains bytes into the uart_tx serializer via
// its load/ready handshake. Define UART_TX_FIFO_IRQ_EN to add the TX-empty irq.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sel,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_ready
`ifdef UART_TX_FIFO_IRQ_EN
    ,
    output logic       irq
`endif
);

    tx_state_t   state, state_nx;
    logic        arm_cnt, arm_cnt_nx;
    logic        wr_data, wr_ctrl, rd_stat;
    logic        flush, pop, ovf;
    logic [7:0]  head;
    logic [AW:0] count;
    logic        full, empty;

    function automatic logic [7:0] status_byte(input logic o, input logic e,
                                               input logic f, input logic [4:0] c);
        logic [7:0] s;
        s           = {3'b000, c};
        s[ST_OVF]   = o;
        s[ST_EMPTY] = e;
        s[ST_FULL]  = f;
        return s;
    endfunction

    assign wr_data = sel & we & (addr == UART_REG_DATA);
    assign wr_ctrl = sel & we & (addr == UART_REG_STAT);
    assign rd_stat = sel & ~we & (addr == UART_REG_STAT);
    assign flush   = wr_ctrl & din[CT_FLUSH];
    // A flush on the same edge suppresses the pop, leaving the FIFO truly empty.
    assign pop     = (state == TX_IDLE) & ~empty & tx_ready & ~flush;

    sync_fifo #(.DEPTH(DEPTH), .AW(AW), .DATA_W(8)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_data),
        .pop     (pop),
        .flush   (flush),
        .din     (din),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= TX_IDLE;
            arm_cnt <= 1'b0;
        end else begin
            state   <= state_nx;
            arm_cnt <= arm_cnt_nx;
        end
    end

    // ARM gives the serializer two cycles to drop ready before assuming it is busy.
    always_comb begin
        state_nx   = state;
        arm_cnt_nx = 1'b0;
        case (state)
            TX_IDLE: if (pop) state_nx = TX_LOAD;
            TX_LOAD: state_nx = TX_ARM;
            TX_ARM: begin
                if (!tx_ready || arm_cnt) state_nx = TX_BUSY;
                else arm_cnt_nx = 1'b1;
            end
            TX_BUSY: if (tx_ready) state_nx = TX_IDLE;
            default: state_nx = TX_IDLE;
        endcase
    end

    assign tx_load = (state == TX_LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data <= 8'h00;
            dout    <= 8'h00;
            ovf     <= 1'b0;
        end else begin
            if (pop) tx_data <= head;
            dout <= rd_stat ? status_byte(ovf, empty, full, 5'(count)) : 8'h00;
            if (flush)               ovf <= 1'b0;
            else if (wr_data & full) ovf <= 1'b1;
            else if (rd_stat)        ovf <= 1'b0;
        end
    end

`ifdef UART_TX_FIFO_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_en <= din[CT_IRQEN];
            irq <= irq_en & empty & (state == TX_IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vector table, multi-cycle corner sequences and
// a randomized run against a queue-based model with a behavioural serializer.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sel, we, addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
`ifdef UART_TX_FIFO_IRQ_EN
    logic       irq;
`endif

    logic       ser_auto = 1'b0;
    logic       man_ready = 1'b1;
    logic       ser_ready;
    int         ser_lo = 10, ser_hi = 10;
    int         busy;
    int         viol;
    logic [7:0] rx_q[$];

    int errors = 0;
    int checks = 0;

    assign tx_ready = ser_auto ? ser_ready : man_ready;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready)
`ifdef UART_TX_FIFO_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    initial forever #5 clk = ~clk;

    // Serializer: records every cycle tx_load is high; in auto mode it drops
    // ready on a load and raises it again after a busy period.
    initial begin
        ser_ready = 1'b1;
        busy      = 0;
        viol      = 0;
        forever begin
            @(negedge clk);
            if (tx_load === 1'b1) begin
                rx_q.push_back(tx_data);
                if (ser_auto) begin
                    if (!ser_ready) viol++;
                    ser_ready = 1'b0;
                    busy      = $urandom_range(ser_hi, ser_lo);
                end
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) ser_ready = 1'b1;
            end
        end
    end

    typedef struct {
        logic       sel, we, addr;
        logic [7:0] din;
        logic       rdy;
        logic [7:0] e_dout;
        logic       e_load;
        logic [7:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic w, input logic a, input logic [7:0] d,
                                input logic r, input logic [7:0] ed, input logic el,
                                input logic [7:0] edata);
        vec_t v;
        v.sel = s; v.we = w; v.addr = a; v.din = d; v.rdy = r;
        v.e_dout = ed; v.e_load = el; v.e_data = edata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic w, input logic a, input logic [7:0] d);
        sel = s; we = w; addr = a; din = d;
    endtask

    task automatic read_status(output logic [7:0] v);
        drive(1'b1, 1'b0, 1'b1, 8'h00);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        v = dout;
    endtask

    vec_t       vt[20];
    logic [7:0] st;
    logic [7:0] b;
    logic [7:0] exp_dout;
    logic [7:0] pending[$];
    logic       m_ovf;
    int         rx_base;
    int         rx_rd;
    int         op;

    task automatic consume_loads();
        while (rx_rd < rx_q.size()) begin
            b = rx_q[rx_rd];
            rx_rd++;
            check("rand_load_expected", 32'(pending.size() > 0), 32'd1);
            if (pending.size() > 0) check("rand_load_order", 32'(b), 32'(pending.pop_front()));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        check("reset_dout", 32'(dout), 32'h00);
        check("reset_tx_load", 32'(tx_load), 32'h0);
        check("reset_tx_data", 32'(tx_data), 32'h00);
`ifdef UART_TX_FIFO_IRQ_EN
        check("reset_irq", 32'(irq), 32'h0);
`endif
        reset_n = 1'b1;
        step();

        // Vector table: single byte with normal serializer, then two bytes
        // with ready held high so the ARM timeout paces the loads.
        vt[0]  = mk(1, 1, 0, 8'h41, 1, 8'h00, 0, 8'h00);
        vt[1]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 1, 8'h41);
        vt[2]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h41);
        vt[3]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h41);
        vt[4]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h41);
        vt[5]  = mk(1, 0, 1, 8'h00, 1, 8'h40, 0, 8'h41);
        vt[6]  = mk(1, 0, 0, 8'h00, 1, 8'h00, 0, 8'h41);
        vt[7]  = mk(1, 1, 0, 8'h5A, 1, 8'h00, 0, 8'h41);
        vt[8]  = mk(1, 1, 0, 8'h5B, 1, 8'h00, 1, 8'h5A);
        vt[9]  = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5A);
        vt[10] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5A);
        vt[11] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5A);
        vt[12] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5A);
        vt[13] = mk(0, 0, 0, 8'h00, 1, 8'h00, 1, 8'h5B);
        vt[14] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5B);
        vt[15] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5B);
        vt[16] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5B);
        vt[17] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5B);
        vt[18] = mk(1, 0, 1, 8'h00, 1, 8'h40, 0, 8'h5B);
        vt[19] = mk(0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h5B);
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].sel, vt[i].we, vt[i].addr, vt[i].din);
            man_ready = vt[i].rdy;
            step();
            check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vt[i].e_dout));
            check($sformatf("vec%0d_tx_load", i), 32'(tx_load), 32'(vt[i].e_load));
            check($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(vt[i].e_data));
        end
        drive(0, 0, 0, 8'h00);

        // Overflow: 17 writes with the serializer stalled.
        man_ready = 1'b0;
        rx_base = rx_q.size();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 8'(8'h80 + i));
            step();
        end
        read_status(st);
        check("ovf_status_first", 32'(st), 32'hB0);
        read_status(st);
        check("ovf_status_second", 32'(st), 32'h30);
        drive(1, 1, 1, 8'h02);
        step();
        read_status(st);
        check("flush_status", 32'(st), 32'h40);
        check("stalled_no_load", 32'(rx_q.size() - rx_base), 32'd0);

        // Drain 16 bytes through a 10-cycle serializer.
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 8'(i));
            step();
        end
        drive(0, 0, 0, 8'h00);
        read_status(st);
        check("fill16_status", 32'(st), 32'h30);
        rx_base  = rx_q.size();
        ser_lo   = 10;
        ser_hi   = 10;
        ser_auto = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("drain_count", 32'(rx_q.size() - rx_base), 32'd16);
        for (int i = 0; i < 16; i++)
            if (rx_base + i < rx_q.size())
                check($sformatf("drain_byte%0d", i), 32'(rx_q[rx_base + i]), 32'(i));
        read_status(st);
        check("drain_status", 32'(st), 32'h40);

        // Flush while the first byte is in flight, five more queued.
        rx_base = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 8'(8'hC0 + i));
            step();
        end
        read_status(st);
        check("busy_queued_status", 32'(st), 32'h05);
        drive(1, 1, 1, 8'h02);
        step();
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 40; i++) step();
        check("flush_busy_loads", 32'(rx_q.size() - rx_base), 32'd1);
        if (rx_q.size() > rx_base) check("flush_busy_byte", 32'(rx_q[rx_base]), 32'hC0);
        read_status(st);
        check("flush_busy_status", 32'(st), 32'h40);
        ser_auto = 1'b0;

`ifdef UART_TX_FIFO_IRQ_EN
        man_ready = 1'b1;
        drive(1, 1, 1, 8'h01);
        step();
        check("irq_en_write", 32'(irq), 32'h0);
        drive(0, 0, 0, 8'h00);
        step();
        check("irq_idle_empty", 32'(irq), 32'h1);
        drive(1, 1, 0, 8'h33);
        step();
        check("irq_write_edge", 32'(irq), 32'h1);
        drive(0, 0, 0, 8'h00);
        step();
        check("irq_dropped", 32'(irq), 32'h0);
        check("irq_load", 32'(tx_load), 32'h1);
        man_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        man_ready = 1'b1;
        step();
        check("irq_busy_exit", 32'(irq), 32'h0);
        step();
        check("irq_rise", 32'(irq), 32'h1);
        drive(1, 1, 1, 8'h00);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        check("irq_disabled", 32'(irq), 32'h0);
`endif

        // Asynchronous reset in the LOAD cycle.
        man_ready = 1'b1;
        drive(1, 1, 0, 8'h77);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        check("pre_reset_load", 32'(tx_load), 32'h1);
        check("pre_reset_data", 32'(tx_data), 32'h77);
        reset_n = 1'b0;
        #1;
        check("async_reset_load", 32'(tx_load), 32'h0);
        check("async_reset_data", 32'(tx_data), 32'h00);
        step();
        reset_n = 1'b1;
        rx_base = rx_q.size();
        for (int i = 0; i < 6; i++) step();
        check("post_reset_no_load", 32'(rx_q.size() - rx_base), 32'd0);
        read_status(st);
        check("post_reset_status", 32'(st), 32'h40);
`ifdef UART_TX_FIFO_IRQ_EN
        check("post_reset_irq", 32'(irq), 32'h0);
`endif

        // Randomized traffic against a queue model of the FIFO.
        ser_lo   = 2;
        ser_hi   = 12;
        viol     = 0;
        ser_auto = 1'b1;
        m_ovf    = 1'b0;
        exp_dout = 8'h00;
        rx_rd    = rx_q.size();
        for (int c = 0; c < 1000; c++) begin
            step();
            consume_loads();
            check("rand_dout", 32'(dout), 32'(exp_dout));
            exp_dout = 8'h00;
            op = $urandom_range(0, 9);
            if (op < 5) begin
                b = 8'($urandom);
                drive(1, 1, 0, b);
                if (pending.size() == DEPTH) m_ovf = 1'b1;
                else pending.push_back(b);
            end else if (op == 5) begin
                drive(1, 0, 1, 8'($urandom));
                exp_dout = {m_ovf, (pending.size() == 0), (pending.size() == DEPTH),
                            5'(pending.size())};
                m_ovf = 1'b0;
            end else if (op == 6) begin
                drive(1, 0, 0, 8'($urandom));
            end else begin
                drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
            end
        end
        drive(0, 0, 0, 8'h00);
        step();
        consume_loads();
        check("rand_dout_last", 32'(dout), 32'(exp_dout));
        for (int c = 0; c < 600 && pending.size() > 0; c++) begin
            step();
            consume_loads();
        end
        check("rand_drain_done", 32'(pending.size()), 32'd0);
        for (int c = 0; c < 20; c++) begin
            step();
            consume_loads();
        end
        read_status(st);
        check("rand_final_status", 32'(st), 32'({m_ovf, 7'h40}));
        check("serializer_protocol", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
